// File: rtl/axi_pkg.sv
// Shared AXI4-lite read-side definitions: response codes, responder FSM
// state encoding and the address/data bus widths.
package axi_pkg;

    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/axi_rd_responder_if.sv
// AR and R channel bundle between a read initiator (master) and the
// memory-side responder (slave).
interface axi_rd_responder_if;
    import axi_pkg::*;

    logic [AXI_ADDR_W-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [AXI_DATA_W-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi_rd_mem_array.sv
// Word storage for the read responder: one synchronous write port and one
// combinational read port, both indexed by word. Contents are never reset.
module axi_rd_mem_array
    import axi_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDXW-1:0]       waddr_i,
    input  logic [AXI_DATA_W-1:0] wdata_i,
    input  logic [IDXW-1:0]       raddr_i,
    output logic [AXI_DATA_W-1:0] rdata_o
);

    logic [AXI_DATA_W-1:0] mem_q [DEPTH];

    // Store a word on the rising edge when the write strobe is high.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4-lite read responder: accepts one AR beat, waits LAT cycles, returns
// one 64-bit R beat from the internal word array.
// Optional macro AXI_RD_RANGE_CHECK_EN: reads outside the mapped window return
// SLVERR with zero data and out-of-window writes are dropped; without it the
// word index wraps modulo DEPTH and RRESP is always OKAY.
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int unsigned           DEPTH     = 4096,
    parameter int unsigned           LAT       = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_rd_responder_if.slave     s_axi,
    input  logic                  wr_en,
    input  logic [AXI_ADDR_W-1:0] wr_addr,
    input  logic [AXI_DATA_W-1:0] wr_data
);

    localparam int unsigned IDXW = $clog2(DEPTH);
`ifdef AXI_RD_RANGE_CHECK_EN
    localparam logic [AXI_ADDR_W-1:0] MEM_BYTES = AXI_ADDR_W'(DEPTH) * 64'd8;
`endif

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic [AXI_ADDR_W-1:0] rd_addr;
    logic [AXI_ADDR_W-1:0] rd_off;
    logic [IDXW-1:0]       rd_idx;
    logic [AXI_DATA_W-1:0] rd_word;
    logic [AXI_DATA_W-1:0] rd_data_d;
    logic [1:0]            rd_resp_d;

    logic [AXI_ADDR_W-1:0] wr_off;
    logic [IDXW-1:0]       wr_idx;
    logic                  wr_we;

    // Write path: byte address to word index, low three bits dropped.
    always_comb begin
        wr_off = wr_addr - BASE_ADDR;
        wr_idx = IDXW'(wr_off >> 3);
`ifdef AXI_RD_RANGE_CHECK_EN
        wr_we  = wr_en && (wr_addr >= BASE_ADDR) && (wr_off < MEM_BYTES);
`else
        wr_we  = wr_en;
`endif
    end

    axi_rd_mem_array #(
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_mem (
        .clk_i   (ACLK),
        .we_i    (wr_we),
        .waddr_i (wr_idx),
        .wdata_i (wr_data),
        .raddr_i (rd_idx),
        .rdata_o (rd_word)
    );

    // Read index: in IDLE the live ARADDR is used so LAT==0 can sample at the
    // handshake edge; otherwise the latched request address.
    always_comb begin
        rd_addr = (state_q == IDLE) ? s_axi.ARADDR : addr_q;
        rd_off  = rd_addr - BASE_ADDR;
        rd_idx  = IDXW'(rd_off >> 3);
    end

    // Read data: shift the word right by the byte offset, zero-filling the top.
    always_comb begin
        rd_data_d = rd_word >> {rd_addr[2:0], 3'b000};
        rd_resp_d = RESP_OKAY;
`ifdef AXI_RD_RANGE_CHECK_EN
        if ((rd_addr < BASE_ADDR) || (rd_off >= MEM_BYTES)) begin
            rd_data_d = '0;
            rd_resp_d = RESP_SLVERR;
        end
`endif
    end

    // Request FSM with latency counter and registered channel outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi.ARVALID && arready_q) begin
                        addr_q    <= s_axi.ARADDR;
                        cnt_q     <= 4'(LAT);
                        arready_q <= 1'b0;
                        if (LAT == 0) begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_data_d;
                            rresp_q  <= rd_resp_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_data_d;
                        rresp_q  <= rd_resp_d;
                    end
                end
                RESP: begin
                    if (RREADY_hs()) begin
                        state_q   <= IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    function automatic logic RREADY_hs();
        return rvalid_q && s_axi.RREADY;
    endfunction

    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
- Memory-side AXI4-lite read responder (slave): the other end of the read-initiator used by the instruction-fetch and load paths.
- Accepts one read address on the AR channel, waits a programmable latency, then returns one 64-bit beat on the R channel.
- Backed by an internal word array with a simple write/preload port; sits between the fetch/LSU read initiators and simulation memory.

Parameters:
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address mapped to word 0
- DEPTH, 4096, number of 64-bit words (power of 2)
- LAT, 2, cycles between AR handshake and RVALID assertion (0..15)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset; the block has one clock, reset is asynchronous and active-low
- ARADDR  in  64  read byte address
- ARVALID  in  1  address valid
- ARREADY  out  1  address accepted
- RDATA  out  64  read data
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
- RVALID  out  1  data valid
- RREADY  in  1  initiator ready for data
- wr_en  in  1  preload/store write strobe
- wr_addr  in  64  write byte address, 8-byte aligned
- wr_data  in  64  write data

Behaviour:
- Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=00, FSM=IDLE, counter=0.
- Reset is asynchronous and may assert mid-transaction. Any pending request is dropped. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID&&ARREADY, latch ARADDR and load the counter with LAT.
  - If LAT==0, go straight to RESP on the next edge; otherwise go to WAIT.
- WAIT:
  - ARREADY=0; the counter decrements each cycle.
  - When the counter reaches 1, read memory and go to RESP on the next edge.
- RESP:
  - RVALID=1; RDATA and RRESP are held stable until RREADY.
  - On RVALID&&RREADY, go to IDLE. ARREADY rises the following cycle, so there is no back-to-back acceptance.
  - Minimum AR-to-R latency is LAT+1 cycles.
- Addressing:
  - Word index = (addr - BASE_ADDR) >> 3.
  - RDATA = mem[idx] >> (8*addr[2:0]), so a 4-byte-aligned instruction at addr[2]=1 appears in RDATA[31:0]. Vacated upper bits are zero.
- Write port:
  - wr_en writes mem[(wr_addr-BASE_ADDR)>>3] at the rising edge.
  - A write and a read sample of the same word in the same cycle returns the OLD value.
  - wr_addr[2:0] are ignored.
- Out-of-range addresses (without the optional feature):
  - The index wraps modulo DEPTH; RRESP is always OKAY.
  - Out-of-range writes also wrap.
- ARVALID deasserting before the handshake is legal and has no effect.
- RREADY held high before RVALID is legal; the beat completes in its first RVALID cycle.

Optional Feature:
- Macro: AXI_RD_RANGE_CHECK_EN.
- When defined:
  - A read with (addr - BASE_ADDR) >= DEPTH*8, or addr < BASE_ADDR, returns RRESP=2'b10 and RDATA=0 with the same timing.
  - An out-of-range write is discarded.
- When undefined: wrap behaviour as above; RRESP is tied to 2'b00.

Decomposition:
- Shared package axi_pkg holds:
  - the RESP_OKAY / RESP_SLVERR constants;
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the AXI data/address width constants (64/64).
- One natural sub-module, axi_rd_mem_array: the word storage with one synchronous write port and one read port indexed by word. The FSM, counter and shift logic stay in the top module.

Test Plan:
- Preload mem[0]=64'h1111_2222_3333_4444 via wr_en; ARADDR=BASE, LAT=2, RREADY=1 -> ARREADY at cycle 0, RVALID at cycle 3, RDATA=64'h1111_2222_3333_4444, RRESP=00, single beat.
- ARADDR=BASE+4 on the same word -> RDATA=64'h0000_0000_1111_2222.
- RREADY held 0 for 5 cycles after RVALID -> RVALID and RDATA stable all 5 cycles; the beat completes on the RREADY cycle; ARREADY=1 the next cycle.
- Assert ARESETn=0 asynchronously while in WAIT -> RVALID=0 and ARREADY=0 immediately. After release, a fresh read completes correctly with no stale beat.
- Write mem[1]=64'hAA on the same cycle the read of word 1 samples memory -> returns the old value. A second read returns 64'hAA.
- ARADDR=BASE+DEPTH*8:
  - without the macro -> RDATA=mem[0], RRESP=00;
  - with AXI_RD_RANGE_CHECK_EN -> RDATA=0, RRESP=2'b10.
